shift_lr_deser: RTL
===================

// Module: shift_lr_deser
// PURPOSE
//  Receive end of the shift_lr serial path: collects a serial bit stream into WIDTH-bit words.
//  Direction per frame: MSB-first (left shift) or LSB-first (right shift).
//  Completed words sit in a holding register with a valid/ready handshake.
//  Sticky overrun flag reports words lost while the holding register is full.
// PARAMETERS
//  WIDTH   8   word width in bits, >= 2; bit counter width = $clog2(WIDTH)
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  reset      in   1      asynchronous, active-low; 0 = all state cleared immediately
//  clear      in   1      sync abort: drops partial frame, clears overrun
//  sel        in   1      direction: 0 = left/MSB-first, 1 = right/LSB-first
//  sin        in   1      serial data bit
//  sin_valid  in   1      sin is valid this cycle (one bit per asserted cycle)
//  out_ready  in   1      consumer accepts out this cycle
//  out        out  WIDTH  assembled word (holding register)
//  out_valid  out  1      out holds an unconsumed word
//  busy       out  1      partial frame in progress (bit count != 0)
//  overrun    out  1      sticky: a completed word was dropped
// BEHAVIOUR
//  - Reset (reset=0): sr, cnt, dir, out, out_valid, overrun all 0, so busy=0. Async assert, sync release.
//  - Direction: sampled into dir only on a sin_valid cycle with cnt==0. sel is ignored mid-frame.
//  - Shift on sin_valid, with nxt as the shifted value:
//    - dir=0: nxt = {sr[WIDTH-2:0], sin}; the first bit lands in the MSB.
//    - dir=1: nxt = {sin, sr[WIDTH-1:1]}; the first bit lands in the LSB.
//    - sr <= nxt; cnt <= cnt+1.
//  - Cycles with sin_valid=0 hold sr and cnt. Gaps are allowed anywhere in a frame.
//  - Frame complete (sin_valid and cnt==WIDTH-1):
//    - cnt <= 0 (wraps) and sr <= 0.
//    - The word goes to out if the holding register is free, i.e. out_valid==0 or out_ready==1 this cycle.
//    - Otherwise the new word is dropped, out is unchanged and overrun <= 1.
//  - Latency: out/out_valid update on the same edge that samples the WIDTH-th bit. Visible the following cycle.
//  - Handshake:
//    - When out_valid && out_ready, out_valid falls next cycle, unless a word completes that cycle; then out_valid stays 1 and out takes the new word.
//    - out is stable while out_valid && !out_ready.
//  - clear: cnt, sr and overrun are set to 0. Priority over sin_valid in the same cycle (that bit is discarded).
//    out and out_valid are unaffected.
//  - busy = (cnt != 0), combinational from the register.
//  - Back-to-back frames: a bit arriving the cycle after completion starts a new frame (dir re-sampled). There is no dead cycle.
//  - Reset mid-frame: the partial word is lost, and outputs go to 0 without waiting for clk.
// STRUCTURE
//  - shift_pkg holds:
//    - localparams DIR_LEFT=1'b0 and DIR_RIGHT=1'b1
//    - default WIDTH=8
//    - a function next_shift(sr, sin, dir) shared with shift_lr
//  - One sub-module, shift_bit_cnt: mod-WIDTH counter with inc, clr and a wrap strobe (cnt==WIDTH-1 && inc).
//  - The top level holds sr, dir, the holding register and overrun logic.
// TESTING
//  1. sel=0, bits 1,0,1,1,0,1,0,0 on consecutive cycles, out_ready=1 -> out=8'hB4, out_valid high 1 cycle, busy high bits 2-8.
//  2. sel=1, same bit sequence -> out=8'h2D. A sel toggle after bit 1 has no effect.
//  3. Bits of 8'h5A MSB-first with random 0-3 cycle sin_valid gaps -> out=8'h5A; cnt frozen during gaps.
//  4. out_ready=0, two frames 8'h11 then 8'h22 -> out stays 8'h11, overrun=1.
//     Then out_ready=1 drains 8'h11; clear -> overrun=0.
//  5. Back-to-back frames 8'hA5, 8'h3C with out_ready asserted on the completion cycle -> out_valid stays 1, out=8'h3C. No overrun.
//  6. reset=0 mid-cycle after bit 4 -> all outputs 0 before next edge. Release, then 8'hF0 frame -> out=8'hF0.
//  Round trip: shift_lr q[WIDTH-1] in left mode drives sin -> the loaded word is recovered intact.

Source files
------------

// File: rtl/shift_lr_deser_pkg.sv
// Shared definitions for the shift_lr serial path (transmit and receive ends).
package shift_lr_deser_pkg;

    localparam logic DIR_LEFT  = 1'b0;  // MSB-first
    localparam logic DIR_RIGHT = 1'b1;  // LSB-first
    localparam int   WIDTH_DEF = 8;
    localparam int   SHIFT_MAX = 64;    // widest word the shared shift helper supports

    // One serial shift step on a zero-extended word of 'width' bits.
    // Left: new bit enters at bit 0. Right: new bit enters at bit width-1.
    function automatic logic [SHIFT_MAX-1:0] next_shift(
        input logic [SHIFT_MAX-1:0] sr,
        input logic                 sin,
        input logic                 dir,
        input int                   width
    );
        logic [SHIFT_MAX-1:0] mask;
        logic [SHIFT_MAX-1:0] res;
        mask = (SHIFT_MAX'(1) << width) - SHIFT_MAX'(1);
        if (dir == DIR_LEFT) begin
            res = ((sr << 1) | SHIFT_MAX'(sin)) & mask;
        end else begin
            res = ((sr & mask) >> 1) | (SHIFT_MAX'(sin) << (width - 1));
        end
        return res;
    endfunction

endpackage

// File: rtl/shift_lr_deser_if.sv
// Serial-in / word-out bundle of the deserializer. master = producer/consumer side, slave = deserializer.
interface shift_lr_deser_if
    import shift_lr_deser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             clear;
    logic             sel;
    logic             sin;
    logic             sin_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    modport master (
        output clear, sel, sin, sin_valid, out_ready,
        input  out, out_valid, busy, overrun
    );

    modport slave (
        input  clear, sel, sin, sin_valid, out_ready,
        output out, out_valid, busy, overrun
    );
endinterface

// File: rtl/shift_lr_deser_bit_cnt.sv
// Mod-WIDTH bit counter; wrap pulses on the increment that returns it to zero.
module shift_lr_deser_bit_cnt
    import shift_lr_deser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          wrap
);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Next count: clear wins, then increment with wrap at WIDTH-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign wrap = inc && !clr && (cnt_q == LAST);
endmodule

// File: rtl/shift_lr_deser.sv
// Serial-to-word receiver with per-frame direction, holding register handshake and sticky overrun.
module shift_lr_deser
    import shift_lr_deser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic clk,
    input logic reset,
    shift_lr_deser_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr_d, sr_q;
    logic             dir_d, dir_q;
    logic [WIDTH-1:0] out_d, out_q;
    logic             out_valid_d, out_valid_q;
    logic             overrun_d, overrun_q;

    logic [CW-1:0]    cnt;
    logic             wrap;
    logic             shift_en;
    logic             frame_start;
    logic             dir_eff;
    logic             hold_free;
    logic [WIDTH-1:0] nxt;

    // A bit discarded by clear must not advance the frame.
    assign shift_en    = bus.sin_valid && !bus.clear;
    assign frame_start = (cnt == '0);
    // The first bit of a frame already uses the freshly sampled direction.
    assign dir_eff     = frame_start ? bus.sel : dir_q;
    assign hold_free   = !out_valid_q || bus.out_ready;
    assign nxt         = WIDTH'(next_shift(SHIFT_MAX'(sr_q), bus.sin, dir_eff, WIDTH));

    shift_lr_deser_bit_cnt #(.WIDTH(WIDTH), .CW(CW)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (shift_en),
        .clr   (bus.clear),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    // Shift register, direction latch, holding register and overrun next-state.
    always_comb begin
        sr_d        = sr_q;
        dir_d       = dir_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        if (bus.clear) begin
            sr_d      = '0;
            overrun_d = 1'b0;
        end else if (shift_en) begin
            if (frame_start) dir_d = bus.sel;
            if (wrap) begin
                sr_d = '0;
                if (hold_free) begin
                    out_d       = nxt;
                    out_valid_d = 1'b1;
                end else begin
                    overrun_d   = 1'b1;
                end
            end else begin
                sr_d = nxt;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q        <= '0;
            dir_q       <= DIR_LEFT;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            dir_q       <= dir_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (cnt != '0);
    assign bus.overrun   = overrun_q;
endmodule
